// File: rtl/cache_control.sv
// Control FSM for a 2-way set-associative, write-back, write-allocate L1 cache with hit/miss counters.
// Latency: hits respond in the request cycle; misses take the pmem latency (twice if a dirty victim) plus one cycle.
// Backpressure: the CPU holds its request until mem_resp; pmem requests are held until pmem_resp.
module cache_control #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [15:0]          mem_address,
    output logic                 mem_resp,
    input  logic                 hit,
    input  logic                 set_one_hit,
    input  logic                 set_two_hit,
    input  logic                 current_lru,
    input  logic                 set_one_valid,
    input  logic                 set_two_valid,
    input  logic                 set_one_dirty,
    input  logic                 set_two_dirty,
    input  logic [8:0]           set_one_tag,
    input  logic [8:0]           set_two_tag,
    output logic                 load_set_one,
    output logic                 load_set_two,
    output logic                 write_type_set_one,
    output logic                 write_type_set_two,
    output logic                 cache_in_mux_sel,
    output logic                 insert_mux_sel,
    output logic                 pmem_w_mux_sel,
    output logic                 load_lru,
    output logic                 pmem_read,
    output logic                 pmem_write,
    output logic [15:0]          pmem_address,
    input  logic                 pmem_resp,
    input  logic                 counter_clear,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t state;
    logic   miss_pending;
    logic   victim;

    logic       req;
    logic       hit_evt;
    logic       miss_evt;
    logic       lru_victim_dirty;
    logic [8:0] victim_tag;
    logic       unused_offset;

    assign req              = mem_read | mem_write;
    assign hit_evt          = (state == IDLE) && req && hit;
    assign miss_evt         = (state == IDLE) && req && !hit;
    assign lru_victim_dirty = current_lru ? (set_two_valid & set_two_dirty)
                                          : (set_one_valid & set_one_dirty);
    assign victim_tag       = victim ? set_two_tag : set_one_tag;
    assign unused_offset    = ^mem_address[3:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            miss_pending <= 1'b0;
            victim       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hit_evt) begin
                        miss_pending <= 1'b0;
                    end else if (miss_evt) begin
                        victim       <= current_lru;
                        miss_pending <= 1'b1;
                        state        <= lru_victim_dirty ? WRITEBACK : ALLOCATE;
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) state <= ALLOCATE;
                end
                ALLOCATE: begin
                    if (pmem_resp) begin
                        state <= IDLE;
                        // An abandoned miss must not suppress counting of the next unrelated hit.
                        if (!req) miss_pending <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (counter_clear) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_evt && !miss_pending && hit_count != CNT_MAX)
                hit_count <= hit_count + CNT_ONE;
            if (miss_evt && miss_count != CNT_MAX)
                miss_count <= miss_count + CNT_ONE;
        end
    end

    always_comb begin
        mem_resp           = 1'b0;
        load_set_one       = 1'b0;
        load_set_two       = 1'b0;
        write_type_set_one = 1'b0;
        write_type_set_two = 1'b0;
        cache_in_mux_sel   = 1'b0;
        insert_mux_sel     = 1'b0;
        pmem_w_mux_sel     = 1'b0;
        load_lru           = 1'b0;
        pmem_read          = 1'b0;
        pmem_write         = 1'b0;
        pmem_address       = 16'h0000;
        case (state)
            IDLE: begin
                if (hit_evt) begin
                    mem_resp = 1'b1;
                    load_lru = 1'b1;
                    if (mem_write) begin
                        cache_in_mux_sel = 1'b1;
                        if (set_one_hit) begin
                            load_set_one       = 1'b1;
                            write_type_set_one = 1'b1;
                        end else if (set_two_hit) begin
                            load_set_two       = 1'b1;
                            write_type_set_two = 1'b1;
                        end
                    end
                end
            end
            WRITEBACK: begin
                pmem_write     = 1'b1;
                pmem_w_mux_sel = victim;
                pmem_address   = {victim_tag, mem_address[6:4], 4'b0000};
            end
            ALLOCATE: begin
                pmem_read    = 1'b1;
                pmem_address = {mem_address[15:4], 4'b0000};
                if (pmem_resp) begin
                    load_set_one = ~victim;
                    load_set_two = victim;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: doc/cache_control.md
Name: cache_control

Overview:
- Control FSM for the 2-way set-associative, write-back, write-allocate L1 cache datapath (8 sets, 16-byte lines, 9-bit tag = addr[15:7], index = addr[6:4], offset = addr[3:0]).
- Sequences hit service, dirty-victim writeback and line refill between the CPU-side port and the physical-memory port, and drives all datapath selects and loads.
- Keeps saturating hit and miss counters for performance measurement.

Parameters:
CNT_WIDTH, 16, width of hit_count and miss_count

Ports:
clk  input  1  sole clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
mem_read  input  1  CPU read request (held until mem_resp)
mem_write  input  1  CPU write request (held until mem_resp); never asserted together with mem_read
mem_address  input  16  CPU byte address
mem_resp  output  1  CPU access complete
hit  input  1  datapath tag match in either way
set_one_hit  input  1  way-1 match
set_two_hit  input  1  way-2 match
current_lru  input  1  LRU way of indexed set; 0 = way 1, 1 = way 2
set_one_valid / set_two_valid  input  1 each  valid bits of indexed set
set_one_dirty / set_two_dirty  input  1 each  dirty bits of indexed set
set_one_tag / set_two_tag  input  9 each  stored tags of indexed set
load_set_one / load_set_two  output  1 each  write the selected way
write_type_set_one / write_type_set_two  output  1 each  1 = CPU write (sets dirty), 0 = clean fill
cache_in_mux_sel  output  1  0 = pmem_rdata, 1 = byte-inserted data
insert_mux_sel  output  1  0 = cached line, 1 = pmem_rdata; tied 0
pmem_w_mux_sel  output  1  writeback source; 0 = way 1, 1 = way 2
load_lru  output  1  update LRU from hit signals
pmem_read  output  1  physical line read request
pmem_write  output  1  physical line write request
pmem_address  output  16  line address; low 4 bits always 0
pmem_resp  input  1  physical memory transaction done (single-cycle pulse)
counter_clear  input  1  synchronous clear of both counters
hit_count  output  CNT_WIDTH  accesses completed without a miss
miss_count  output  CNT_WIDTH  accesses that missed

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset state: state = IDLE; miss_pending = 0; victim = 0; counters = 0; every output = 0 (combinational outputs evaluate to 0 in IDLE with no request).
- Reset asserted mid-transaction: return to IDLE immediately and drop pmem_read/pmem_write; no mem_resp.
- FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE, request present and hit = 1:
  - mem_resp = 1 in the same cycle; load_lru = 1.
  - Write: load the matching way with cache_in_mux_sel = 1 and write_type = 1 for that way.
  - Read: no load.
  - Stay in IDLE.
  - hit_count increments if miss_pending = 0; clear miss_pending.
- IDLE, request present and hit = 0:
  - victim <= current_lru; miss_count++; miss_pending <= 1.
  - Go to WRITEBACK if the victim way is valid and dirty, else ALLOCATE.
  - No mem_resp this cycle.
- WRITEBACK:
  - pmem_write = 1; pmem_w_mux_sel = victim.
  - pmem_address = {victim tag, mem_address[6:4], 4'b0}.
  - On pmem_resp, go to ALLOCATE.
- ALLOCATE:
  - pmem_read = 1; pmem_address = {mem_address[15:4], 4'b0}.
  - On pmem_resp: load the victim way (cache_in_mux_sel = 0, write_type = 0), then go to IDLE.
  - The held request then hits in IDLE and is served there; that hit updates the LRU and merges write data.
- Latency: read or write hit = 0 extra cycles (response in the request cycle). Miss = memory latency(s) + 1 cycle.
- pmem_read and pmem_write are never both 1; each is held continuously until pmem_resp.
- Request deasserted during a miss: the pmem transaction is still completed, the line is filled, and the FSM returns to IDLE with no mem_resp.
- Counters: saturate at all-ones, no wrap. counter_clear takes priority over a same-cycle increment.

Test Plan:
- Cold read of 0x1234 (both ways invalid), pmem latency 3 → ALLOCATE with pmem_address = 0x1230. Fill into way 1, then mem_resp the cycle after pmem_resp. miss_count = 1, hit_count = 0.
- Read of 0x1234 repeated → mem_resp in the same cycle, load_lru = 1, no pmem activity. hit_count = 1.
- Write hit to 0x1236 with way 2 matching → load_set_two = 1, write_type_set_two = 1, cache_in_mux_sel = 1, mem_resp = 1, all in one cycle.
- Miss with dirty victim (tag 0x024, index 3, current_lru = 1):
  - pmem_write = 1, pmem_w_mux_sel = 1, pmem_address = 0x1230.
  - Then pmem_read on the new line address.
  - Then mem_resp.
- rst_n pulled low during ALLOCATE → pmem_read = 0 immediately and state = IDLE. After release, the same request misses again and miss_count increments.
- Counter saturation with CNT_WIDTH = 2: five hits → hit_count = 3. counter_clear together with a hit → hit_count = 0.
